// File: rtl/dmem_arbiter_if.sv
// Bundles the two requester ports, the shared read-response signals and the
// memory-side strobe/address/data lines of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          lock0;
  logic          gnt0;
  logic          rvalid0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          lock1;
  logic          gnt1;
  logic          rvalid1;

  logic [DW-1:0] rdata;
  logic          core_stall;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0, lock0,
    input  req1, we1, addr1, wdata1, lock1,
    input  mem_rdata,
    output gnt0, rvalid0, gnt1, rvalid1, rdata, core_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0, lock0,
    output req1, we1, addr1, wdata1, lock1,
    output mem_rdata,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata, core_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: round-robin with bounded
// burst locking, one grant per cycle, fixed 1-cycle read latency.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam int            CW          = $clog2(MAX_BURST + 1);
  localparam logic [CW:0]   MAX_BURST_C = (CW + 1)'(MAX_BURST);

  logic          prio_q, prio_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_owner_q, rd_owner_d;

  logic          gnt0_s, gnt1_s, any_gnt_s;
  logic          win_s, win_lock_s, win_we_s;
  logic [CW:0]   cnt_inc_s;

  // Grant decision; reset masks both grants so no memory access leaks out.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (bus.req0 && bus.req1) begin
      gnt0_s = ~prio_q;
      gnt1_s = prio_q;
    end else begin
      gnt0_s = bus.req0;
      gnt1_s = bus.req1;
    end
  end

  assign any_gnt_s  = gnt0_s | gnt1_s;
  assign win_s      = gnt1_s;
  assign win_lock_s = gnt1_s ? bus.lock1 : bus.lock0;
  assign win_we_s   = gnt1_s ? bus.we1 : bus.we0;
  assign cnt_inc_s  = {1'b0, burst_cnt_q} + {{CW{1'b0}}, 1'b1};

  // Memory-side mux from the granted requester, all zero when idle.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {AW{1'b0}};
    bus.mem_wdata = {DW{1'b0}};
    if (gnt1_s) begin
      bus.mem_we    = bus.we1;
      bus.mem_addr  = bus.addr1;
      bus.mem_wdata = bus.wdata1;
    end else if (gnt0_s) begin
      bus.mem_we    = bus.we0;
      bus.mem_addr  = bus.addr0;
      bus.mem_wdata = bus.wdata0;
    end else begin
      bus.mem_we    = 1'b0;
      bus.mem_addr  = {AW{1'b0}};
      bus.mem_wdata = {DW{1'b0}};
    end
  end

  // Next priority / burst count and read-tracking state.
  always_comb begin
    prio_d      = prio_q;
    burst_cnt_d = burst_cnt_q;
    rd_pend_d   = 1'b0;
    rd_owner_d  = rd_owner_q;
    if (any_gnt_s) begin
      // A locking winner keeps priority until it has used MAX_BURST grants.
      if (win_lock_s && (cnt_inc_s < MAX_BURST_C)) begin
        prio_d      = win_s;
        burst_cnt_d = cnt_inc_s[CW-1:0];
      end else begin
        prio_d      = ~win_s;
        burst_cnt_d = {CW{1'b0}};
      end
      rd_pend_d  = ~win_we_s;
      rd_owner_d = win_we_s ? rd_owner_q : win_s;
    end else begin
      prio_d      = prio_q;
      burst_cnt_d = burst_cnt_q;
    end
  end

  // State register with synchronous reset; reset discards any pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= 1'b0;
      burst_cnt_q <= {CW{1'b0}};
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
    end
  end

  assign bus.gnt0       = gnt0_s;
  assign bus.gnt1       = gnt1_s;
  assign bus.mem_en     = any_gnt_s;
  assign bus.core_stall = bus.req0 & ~gnt0_s;
  assign bus.rvalid0    = rd_pend_q & ~rd_owner_q;
  assign bus.rvalid1    = rd_pend_q & rd_owner_q;
  assign bus.rdata      = rd_pend_q ? bus.mem_rdata : {DW{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous-read memory model;
// expected values are written out by hand for each cycle.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] mem_rdata_r;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mem_rdata = mem_rdata_r;

  // Single-port synchronous memory; preloaded while mem_init is high.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4]      <= 32'h1111_0010;
      mem[8]      <= 32'h2222_0020;
      mem_rdata_r <= 32'h0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      else            mem_rdata_r <= mem[bus.mem_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set0(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic l);
    bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; bus.lock0 = l;
  endtask

  task automatic set1(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic l);
    bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = l;
  endtask

  initial begin
    logic [31:0] exp_rd;
    int prev;
    mem_init = 1'b1;
    rst      = 1'b1;
    set0(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    set1(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

    // Reset held with both ports requesting
    for (int k = 0; k < 2; k++) begin
      cyc();
      mid();
      chk("rst_gnt0", bus.gnt0, 32'd0);
      chk("rst_gnt1", bus.gnt1, 32'd0);
      chk("rst_mem_en", bus.mem_en, 32'd0);
      chk("rst_rvalid0", bus.rvalid0, 32'd0);
      chk("rst_rvalid1", bus.rvalid1, 32'd0);
    end

    // Alternation: grants 0,1,0,1 with responses one cycle later
    for (int k = 0; k < 4; k++) begin
      cyc();
      rst      = 1'b0;
      mem_init = 1'b0;
      mid();
      chk("alt_gnt0", bus.gnt0, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_gnt1", bus.gnt1, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("alt_addr", bus.mem_addr, (k % 2 == 0) ? 32'h10 : 32'h20);
      prev   = (k == 0) ? -1 : (k - 1) % 2;
      exp_rd = (prev == 0) ? 32'h1111_0010 : (prev == 1) ? 32'h2222_0020 : 32'h0;
      chk("alt_rvalid0", bus.rvalid0, (prev == 0) ? 32'd1 : 32'd0);
      chk("alt_rvalid1", bus.rvalid1, (prev == 1) ? 32'd1 : 32'd0);
      chk("alt_rdata", bus.rdata, exp_rd);
    end

    // Core alone, sets prio to 1 for the burst test
    cyc();
    set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    mid();
    chk("e_gnt0", bus.gnt0, 32'd1);
    chk("e_rvalid1", bus.rvalid1, 32'd1);
    chk("e_rdata", bus.rdata, 32'h2222_0020);

    // Loader locks for exactly MAX_BURST writes while the core stalls
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) set1(1'b1, 1'b1, 32'h80, 32'hCAFE_0080, 1'b1);
      mid();
      chk("burst_gnt1", bus.gnt1, 32'd1);
      chk("burst_gnt0", bus.gnt0, 32'd0);
      chk("burst_stall", bus.core_stall, 32'd1);
      chk("burst_we", bus.mem_we, 32'd1);
      if (k == 0) begin
        chk("burst_rvalid0", bus.rvalid0, 32'd1);
        chk("burst_rdata", bus.rdata, 32'h1111_0010);
      end
    end
    cyc();
    mid();
    chk("burst_end_gnt0", bus.gnt0, 32'd1);
    chk("burst_end_gnt1", bus.gnt1, 32'd0);
    chk("burst_end_stall", bus.core_stall, 32'd0);

    // Core write then read of 0x40
    cyc();
    set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set0(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
    mid();
    chk("wr_gnt0", bus.gnt0, 32'd1);
    chk("wr_we", bus.mem_we, 32'd1);
    chk("wr_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("wr_rvalid0", bus.rvalid0, 32'd1);
    chk("wr_rdata", bus.rdata, 32'h1111_0010);
    cyc();
    set0(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    mid();
    chk("rd_gnt0", bus.gnt0, 32'd1);
    chk("rd_we", bus.mem_we, 32'd0);
    chk("rd_no_rvalid_after_wr", bus.rvalid0, 32'd0);
    chk("rd_rdata_idle", bus.rdata, 32'h0);
    cyc();
    set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    mid();
    chk("lat_rvalid0", bus.rvalid0, 32'd1);
    chk("lat_rdata", bus.rdata, 32'hDEAD_BEEF);
    chk("lat_rvalid1", bus.rvalid1, 32'd0);
    chk("idle_mem_en", bus.mem_en, 32'd0);
    chk("idle_mem_addr", bus.mem_addr, 32'h0);

    // Locked read granted to port 1, then reset on the very next edge
    cyc();
    set1(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    mid();
    chk("mr_gnt1", bus.gnt1, 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set0(1'b1, 1'b0, 32'h80, 32'h0, 1'b0);
    mid();
    chk("mr_rvalid1", bus.rvalid1, 32'd0);
    chk("mr_prio_gnt0", bus.gnt0, 32'd1);
    chk("mr_prio_gnt1", bus.gnt1, 32'd0);

    // Core alone with lock toggling, back-to-back reads of burst-written word
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (k == 0) set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      bus.lock0 = (k % 2 == 1);
      mid();
      chk("single_gnt0", bus.gnt0, 32'd1);
      chk("single_stall", bus.core_stall, 32'd0);
      chk("single_rvalid0", bus.rvalid0, 32'd1);
      chk("single_rvalid1", bus.rvalid1, 32'd0);
      chk("single_rdata", bus.rdata, 32'hCAFE_0080);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
